// File: rtl/bfm_ahbl_pkg.sv
// rtl/bfm_ahbl_pkg.sv - shared codes, state encoding and legality helper for the AHB-Lite responder
package bfm_ahbl_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_e;

   // addr is the decoded byte address already stripped of the ignored upper bits
   function automatic logic is_illegal(input logic [31:0]  addr,
                                       input logic [2:0]   size,
                                       input logic         misalign,
                                       input int unsigned  mem_words);
      return (addr >= 32'(4 * mem_words)) || (size > HSIZE_WORD) || misalign;
   endfunction

endpackage

// File: rtl/bfm_ahbl_slave_lanes.sv
// rtl/bfm_ahbl_slave_lanes.sv - byte-lane strobe and misalignment decode for one transfer
module bfm_ahbl_slave_lanes
   import bfm_ahbl_pkg::*;
(
   input  logic [2:0] size_i,
   input  logic [1:0] addr_lo_i,
   output logic [3:0] strb_o,
   output logic       misalign_o
);

   always_comb begin
      strb_o     = 4'b0000;
      misalign_o = 1'b0;
      case (size_i)
         HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
         HSIZE_HALF: begin
            strb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            misalign_o = addr_lo_i[0];
         end
         HSIZE_WORD: begin
            strb_o     = 4'b1111;
            misalign_o = (addr_lo_i != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bfm_ahbl_slave.sv
// rtl/bfm_ahbl_slave.sv - AHB-Lite responder memory model with wait states and two-cycle ERROR
module bfm_ahbl_slave
   import bfm_ahbl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned MEM_WORDS   = 64,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [3:0]         strb_q, strb_d;
   logic               write_q, write_d;
   logic [31:0]        mem_q [MEM_WORDS];

   logic [31:0]        addr_dec;
   logic [3:0]         strb;
   logic               misalign;
   logic               illegal;
   logic               accept;
   logic               unused_inputs;

   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:ADDR_WIDTH]};

   assign addr_dec = 32'(HADDR[ADDR_WIDTH-1:0]);

   bfm_ahbl_slave_lanes u_lanes (
      .size_i     (HSIZE),
      .addr_lo_i  (HADDR[1:0]),
      .strb_o     (strb),
      .misalign_o (misalign)
   );

   assign illegal = is_illegal(addr_dec, HSIZE, misalign, MEM_WORDS);
   assign accept  = HSEL && HREADY && !(HTRANS == HTRANS_IDLE || HTRANS == HTRANS_BUSY);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         strb_q  <= 4'd0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         strb_q  <= strb_d;
         write_q <= write_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      strb_d  = strb_q;
      write_d = write_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == WAIT_LAST) state_d = ST_DATA;
            else                    cnt_d   = cnt_q + 4'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
      // WAIT and ERR1 hold HREADY low on the bus, so new transfers only land in the other states
      if (accept && (state_q inside {ST_IDLE, ST_DATA, ST_ERR2})) begin
         idx_d   = HADDR[IDX_W+1:2];
         strb_d  = strb;
         write_d = HWRITE;
         cnt_d   = 4'd0;
         if (illegal)              state_d = ST_ERR1;
         else if (WAIT_STATES > 0) state_d = ST_WAIT;
         else                      state_d = ST_DATA;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
      end else if (state_q == ST_DATA && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign HREADYOUT = !(state_q inside {ST_WAIT, ST_ERR1});
   assign HRESP     = (state_q inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
   assign HRDATA    = (state_q == ST_DATA) ? mem_q[idx_q] : 32'd0;

endmodule

// File: tb/tb_bfm_ahbl_slave.sv
// tb/tb_bfm_ahbl_slave.sv - randomized self-checking bench for bfm_ahbl_slave
module tb_bfm_ahbl_slave;

   typedef struct {
      bit          idle;
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } op_t;

   logic        HCLK = 1'b0;
   logic        HRESET;
   bit          sel;
   logic        hsel, hwrite, hmastlock;
   logic [1:0]  htrans;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic        ro0, rs0, ro1, rs1;
   logic [31:0] rd0, rd1;
   logic        hready, hresp_m;
   logic [31:0] hrdata_m;

   int          checks = 0;
   int          errors = 0;
   string       tname = "init";
   op_t         ops[$];
   logic [31:0] model_mem [2][64];

   always #5 HCLK = ~HCLK;

   // two responders behind a one-hot decode; the data-phase owner drives the bus ready
   assign hready   = sel ? ro1 : ro0;
   assign hresp_m  = sel ? rs1 : rs0;
   assign hrdata_m = sel ? rd1 : rd0;

   bfm_ahbl_slave #(.ADDR_WIDTH(10), .MEM_WORDS(64), .WAIT_STATES(0)) u_dut0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && !sel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
      .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
   );

   bfm_ahbl_slave #(.ADDR_WIDTH(10), .MEM_WORDS(64), .WAIT_STATES(2)) u_dut1 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && sel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
      .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s/%s: got %h expected %h at %0t", tname, tag, obs, exp, $time);
      end
   endtask

   function automatic bit ref_illegal(input logic [31:0] a, input logic [2:0] s);
      int unsigned off;
      off = a % 1024;
      if (off >= 256) return 1'b1;
      if (s > 3'd2) return 1'b1;
      return (off % (1 << s)) != 0;
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a % 1024) / 4);
   endfunction

   task automatic model_write(input bit d, input op_t o);
      int unsigned off;
      int          lane;
      off = o.addr % 1024;
      for (int b = 0; b < (1 << o.size); b++) begin
         lane = int'(off % 4) + b;
         model_mem[d][off / 4][8*lane +: 8] = o.wdata[8*lane +: 8];
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 64; w++) model_mem[d][w] = 32'd0;
   endtask

   task automatic push_op(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata);
      op_t o;
      o.idle = 1'b0; o.wr = wr; o.addr = addr; o.size = size; o.wdata = wdata;
      ops.push_back(o);
   endtask

   task automatic push_idle();
      op_t o;
      o.idle = 1'b1; o.wr = 1'b0; o.addr = $urandom; o.size = 3'd0; o.wdata = 32'd0;
      ops.push_back(o);
   endtask

   // Runs the op queue as a pipelined master; entered and left just after a rising edge
   task automatic run_seq();
      int   ai = 0;
      int   k = 0;
      int   ws;
      bit   dp_v = 1'b0;
      bit   ap_x, rdy, rsp, bad, exp_rdy;
      op_t  dp, ap;
      logic [31:0] rdt;
      ws = sel ? 2 : 0;
      while (ai < ops.size() || dp_v) begin
         ap_x = 1'b0;
         bad  = 1'b0;
         if (ai < ops.size()) begin
            ap   = ops[ai];
            ap_x = 1'b1;
         end
         if (ap_x && !ap.idle) begin
            hsel = 1'b1; htrans = 2'b10; haddr = ap.addr; hwrite = ap.wr; hsize = ap.size;
         end else if (ap_x) begin
            hsel = 1'($urandom_range(0, 1)); htrans = 2'($urandom_range(0, 1));
            haddr = ap.addr; hwrite = 1'($urandom_range(0, 1)); hsize = 3'($urandom_range(0, 2));
         end else begin
            hsel = 1'b0; htrans = 2'b00;
         end
         hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom_range(0, 1));
         hwdata = dp_v ? dp.wdata : $urandom;
         @(negedge HCLK);
         rdy = hready; rsp = hresp_m; rdt = hrdata_m;
         if (dp_v) begin
            bad     = ref_illegal(dp.addr, dp.size);
            exp_rdy = bad ? (k == 1) : (k == ws);
            check("hreadyout", 32'(rdy), 32'(exp_rdy));
            check("hresp", 32'(rsp), 32'(bad));
            if (!bad && exp_rdy && !dp.wr) check("hrdata", rdt, model_mem[sel][word_of(dp.addr)]);
            else if (bad || !exp_rdy)      check("hrdata_zero", rdt, 32'd0);
         end else begin
            check("idle_ready", 32'(rdy), 32'd1);
            check("idle_resp", 32'(rsp), 32'd0);
            check("idle_rdata", rdt, 32'd0);
         end
         @(posedge HCLK);
         #1;
         if (rdy) begin
            if (dp_v && !bad && dp.wr) model_write(sel, dp);
            dp_v = 1'b0;
            if (ap_x) begin
               dp_v = !ap.idle;
               dp   = ap;
               ai++;
            end
            k = 0;
         end else begin
            k++;
            if (k > 20) begin
               check("stall_bound", 32'(k), 32'd20);
               dp_v = 1'b0;
               ai   = ops.size();
            end
         end
      end
      hsel = 1'b0; htrans = 2'b00;
      ops.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      HRESET = 1'b1; sel = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = 32'd0; hwrite = 1'b0;
      hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hwdata = 32'd0;
      clear_model();

      tname = "reset";
      @(negedge HCLK);
      check("ready0", 32'(ro0), 32'd1); check("resp0", 32'(rs0), 32'd0); check("rdata0", rd0, 32'd0);
      check("ready1", 32'(ro1), 32'd1); check("resp1", 32'(rs1), 32'd0); check("rdata1", rd1, 32'd0);
      @(posedge HCLK); #1 HRESET = 1'b0;
      @(posedge HCLK); #1;

      tname = "word_b2b"; sel = 1'b0;
      push_op(1, 32'h10, 3'd2, 32'hDEADBEEF);
      push_op(0, 32'h10, 3'd2, 32'h0);
      run_seq();

      tname = "byte_half"; sel = 1'b0;
      push_op(1, 32'h20, 3'd2, 32'h0);
      push_op(1, 32'h21, 3'd0, {4{8'hAA}});
      push_op(1, 32'h22, 3'd1, {2{16'h1234}});
      push_op(0, 32'h20, 3'd2, 32'h0);
      run_seq();
      check("merged_model", model_mem[0][8], 32'h1234AA00);

      tname = "wait2_read"; sel = 1'b1;
      push_op(0, 32'h04, 3'd2, 32'h0);
      run_seq();

      tname = "range_err"; sel = 1'b1;
      push_op(1, 32'h100, 3'd2, 32'hFFFFFFFF);
      push_op(0, 32'h00, 3'd2, 32'h0);
      run_seq();

      tname = "size_align_err"; sel = 1'b1;
      push_op(1, 32'h20, 3'd2, 32'h5A5AA5A5);
      push_op(0, 32'h03, 3'd1, 32'h0);
      push_op(1, 32'h00, 3'd3, 32'h12345678);
      push_op(0, 32'h20, 3'd2, 32'h0);
      run_seq();

      tname = "reset_mid"; sel = 1'b1;
      push_op(1, 32'h08, 3'd2, 32'hCAFEF00D);
      run_seq();
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'h11111111;
      @(posedge HCLK); #1;
      hsel = 1'b0; htrans = 2'b00;
      check("in_wait", 32'(ro1), 32'd0);
      #2 HRESET = 1'b1;
      #1;
      check("async_ready", 32'(ro1), 32'd1);
      check("async_resp", 32'(rs1), 32'd0);
      check("async_rdata", rd1, 32'd0);
      @(posedge HCLK); @(posedge HCLK); #1 HRESET = 1'b0;
      clear_model();
      @(posedge HCLK); #1;
      push_op(0, 32'h08, 3'd2, 32'h0);
      run_seq();

      for (int d = 0; d < 2; d++) begin
         int          r, woff;
         logic [31:0] a;
         logic [2:0]  sz;
         tname = (d == 0) ? "rand_ws0" : "rand_ws2";
         sel = 1'(d);
         for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) push_idle();
            else begin
               sz   = (r == 1) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
               woff = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 15);
               a    = {$urandom} & 32'hFFFF_FC00;
               a    = a | 32'(woff * 4 + $urandom_range(0, 3));
               push_op(1'($urandom_range(0, 1)), a, sz, $urandom);
            end
         end
         for (int w = 0; w < 16; w++) push_op(0, 32'(w * 4), 3'd2, 32'h0);
         run_seq();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
